// File: rtl/trena_digital_uc.sv
// Control unit for the digital tape measure. It clears the datapath, starts a
// measurement with a timeout, then sends N_CHARS characters over the serial link.
module trena_digital_uc #(
  parameter int TIMEOUT_CICLOS = 3000000,
  parameter int N_CHARS        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mensurar,
  input  logic       medida_pronto,
  input  logic       envio_pronto,
  output logic       zera,
  output logic       medir,
  output logic       transmitir,
  output logic [1:0] sel_char,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int         TW        = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [1:0] LAST_CHAR = 2'(N_CHARS - 1);

  typedef enum logic [3:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARACAO     = 4'h1,
    ST_MEDE           = 4'h2,
    ST_AGUARDA_MEDIDA = 4'h3,
    ST_TRANSMITE      = 4'h4,
    ST_AGUARDA_ENVIO  = 4'h5,
    ST_PROXIMO        = 4'h6,
    ST_FINAL          = 4'h7,
    ST_ERRO           = 4'hE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    char_q, char_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          zera_q, medir_q, transmitir_q, pronto_q, erro_q;

  // NOTE: every next-state variable gets its hold value first so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_INICIAL: begin
        if (mensurar) state_d = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        char_d  = '0;
        tmo_d   = '0;
        state_d = ST_MEDE;
      end
      ST_MEDE: state_d = ST_AGUARDA_MEDIDA;
      ST_AGUARDA_MEDIDA: begin
        // A measurement arriving on the final tick still counts as success.
        if (medida_pronto)           state_d = ST_TRANSMITE;
        else if (tmo_q == LAST_TICK) state_d = ST_ERRO;
        else                         tmo_d   = tmo_q + TW'(1);
      end
      ST_TRANSMITE: state_d = ST_AGUARDA_ENVIO;
      ST_AGUARDA_ENVIO: begin
        if (envio_pronto) state_d = ST_PROXIMO;
      end
      ST_PROXIMO: begin
        if (char_q == LAST_CHAR) begin
          state_d = ST_FINAL;
        end else begin
          char_d  = char_q + 2'd1;
          state_d = ST_TRANSMITE;
        end
      end
      ST_FINAL: state_d = ST_INICIAL;
      ST_ERRO: begin
        if (!mensurar) state_d = ST_INICIAL;
      end
      default: state_d = ST_INICIAL;
    endcase
  end

  // Output flops are loaded from the next state, so each output is a pure
  // function of the registered state with no input-to-output path.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INICIAL;
      char_q       <= '0;
      tmo_q        <= '0;
      zera_q       <= 1'b0;
      medir_q      <= 1'b0;
      transmitir_q <= 1'b0;
      pronto_q     <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      char_q       <= char_d;
      tmo_q        <= tmo_d;
      zera_q       <= (state_d == ST_PREPARACAO);
      medir_q      <= (state_d == ST_MEDE);
      transmitir_q <= (state_d == ST_TRANSMITE);
      pronto_q     <= (state_d == ST_FINAL);
      erro_q       <= (state_d == ST_ERRO);
    end
  end

  assign zera       = zera_q;
  assign medir      = medir_q;
  assign transmitir = transmitir_q;
  assign pronto     = pronto_q;
  assign erro       = erro_q;
  assign sel_char   = char_q;
  assign db_estado  = state_q;

endmodule

// File: tb/tb_trena_digital_uc.sv
// Self-checking bench for trena_digital_uc: a per-cycle vector table plus
// hand-written sequences, with a scoreboard of expected sel_char per transmit.
module tb_trena_digital_uc;

  localparam int TMO = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mensurar = 1'b0;
  logic       medida_pronto = 1'b0;
  logic       envio_pronto = 1'b0;
  logic       zera, medir, transmitir, pronto, erro;
  logic [1:0] sel_char;
  logic [3:0] db_estado;

  trena_digital_uc #(.TIMEOUT_CICLOS(TMO), .N_CHARS(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .mensurar      (mensurar),
    .medida_pronto (medida_pronto),
    .envio_pronto  (envio_pronto),
    .zera          (zera),
    .medir         (medir),
    .transmitir    (transmitir),
    .sel_char      (sel_char),
    .pronto        (pronto),
    .erro          (erro),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int q_sel[$];
  int n_zera = 0, n_medir = 0, n_tx = 0, n_pronto = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: count pulses and compare every transmit against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (zera)   n_zera++;
      if (medir)  n_medir++;
      if (pronto) n_pronto++;
      if (transmitir) begin
        n_tx++;
        if (q_sel.size() == 0) check("unexpected_transmit", 32'(transmitir), 32'd0);
        else                   check("sel_char_scoreboard", 32'(sel_char), 32'(q_sel.pop_front()));
      end
    end
  end

  typedef enum {W_MEDIR, W_TX, W_PRONTO} wsig_e;

  function automatic logic sig_of(input wsig_e w);
    case (w)
      W_MEDIR: return medir;
      W_TX:    return transmitir;
      default: return pronto;
    endcase
  endfunction

  task automatic wait_for(input wsig_e w, input string name);
    for (int i = 0; i < 400; i++) begin
      if (sig_of(w)) break;
      step();
    end
    check(name, 32'(sig_of(w)), 32'd1);
  endtask

  task automatic pulse_medida();
    medida_pronto = 1'b1; step(); medida_pronto = 1'b0;
  endtask

  task automatic pulse_envio();
    envio_pronto = 1'b1; step(); envio_pronto = 1'b0;
  endtask

  task automatic push_message();
    for (int i = 0; i < 4; i++) q_sel.push_back(i);
  endtask

  task automatic serve_chars(input int denv);
    for (int i = 0; i < 4; i++) begin
      wait_for(W_TX, "wait_transmitir");
      repeat (denv) step();
      pulse_envio();
    end
    wait_for(W_PRONTO, "wait_pronto");
  endtask

  task automatic run_message(input int dmed, input int denv);
    wait_for(W_MEDIR, "wait_medir");
    repeat (dmed) step();
    pulse_medida();
    serve_chars(denv);
  endtask

  typedef struct {
    logic       mens, med, env;
    logic [3:0] st;
    logic [4:0] flags;   // {zera, medir, transmitir, pronto, erro}
    logic [1:0] sel;
  } vec_t;

  function automatic vec_t mk(input logic m, input logic d, input logic e,
                              input logic [3:0] st, input logic [4:0] fl, input logic [1:0] sel);
    vec_t v;
    v.mens = m; v.med = d; v.env = e; v.st = st; v.flags = fl; v.sel = sel;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[19];
    int   c_medir, c_tx, c_pr, c_zera, n;

    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 4'h1, 5'b10000, 2'd0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 4'h2, 5'b01000, 2'd0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 4'h3, 5'b00000, 2'd0);  // mensurar ignored
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 4'h3, 5'b00000, 2'd0);  // spurious envio
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 4'h4, 5'b00100, 2'd0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 4'h5, 5'b00000, 2'd0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 4'h5, 5'b00000, 2'd0);  // spurious medida
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 4'h6, 5'b00000, 2'd0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 4'h4, 5'b00100, 2'd1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 4'h5, 5'b00000, 2'd1);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 4'h6, 5'b00000, 2'd1);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 4'h4, 5'b00100, 2'd2);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 4'h5, 5'b00000, 2'd2);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 4'h6, 5'b00000, 2'd2);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 4'h4, 5'b00100, 2'd3);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 4'h5, 5'b00000, 2'd3);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 4'h6, 5'b00000, 2'd3);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 4'h7, 5'b00010, 2'd3);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 4'h0, 5'b00000, 2'd3);

    // Reset state, including a start request that must be ignored in reset.
    step();
    check("reset_outputs", 32'({zera, medir, transmitir, pronto, erro, sel_char, db_estado}), 32'd0);
    mensurar = 1'b1;
    step();
    check("reset_ignores_mensurar", 32'(db_estado), 32'h0);
    mensurar = 1'b0;
    reset = 1'b1;
    step(); step();
    check("idle_after_release", 32'(db_estado), 32'h0);

    // Cycle-accurate table: one short message with spurious inputs.
    push_message();
    foreach (vecs[i]) begin
      mensurar      = vecs[i].mens;
      medida_pronto = vecs[i].med;
      envio_pronto  = vecs[i].env;
      step();
      check($sformatf("vec%0d_state", i), 32'(db_estado), 32'(vecs[i].st));
      check($sformatf("vec%0d_flags", i), 32'({zera, medir, transmitir, pronto, erro}), 32'(vecs[i].flags));
      check($sformatf("vec%0d_sel", i), 32'(sel_char), 32'(vecs[i].sel));
    end
    mensurar = 1'b0; medida_pronto = 1'b0; envio_pronto = 1'b0;
    step();
    check("table_back_idle", 32'(db_estado), 32'h0);

    // Normal message with realistic delays; medir exactly two cycles after start.
    c_medir = n_medir; c_tx = n_tx; c_pr = n_pronto;
    push_message();
    mensurar = 1'b1; step(); mensurar = 1'b0;
    step();
    check("latency_medir", 32'(medir), 32'd1);
    run_message(10, 20);
    step();
    check("normal_medir_count", 32'(n_medir - c_medir), 32'd1);
    check("normal_tx_count", 32'(n_tx - c_tx), 32'd4);
    check("normal_pronto_count", 32'(n_pronto - c_pr), 32'd1);
    check("normal_erro", 32'(erro), 32'd0);
    check("normal_idle", 32'(db_estado), 32'h0);

    // Timeout: erro exactly TMO cycles after entering aguarda_medida.
    c_tx = n_tx;
    mensurar = 1'b1;
    step(); step();
    step();
    check("timeout_enter_wait", 32'(db_estado), 32'h3);
    n = 0;
    while (db_estado != 4'hE && n < 200) begin step(); n++; end
    check("timeout_cycles", 32'(n), 32'(TMO));
    check("timeout_erro", 32'(erro), 32'd1);
    check("timeout_no_tx", 32'(n_tx - c_tx), 32'd0);
    repeat (3) step();
    check("erro_held_while_mensurar", 32'(db_estado), 32'hE);
    mensurar = 1'b0;
    step();
    check("erro_release", 32'({erro, db_estado}), 32'h0);

    // Race: medida_pronto on the last timeout cycle wins.
    push_message();
    mensurar = 1'b1; step(); mensurar = 1'b0;
    step(); step();
    repeat (TMO - 1) step();
    check("race_still_waiting", 32'(db_estado), 32'h3);
    pulse_medida();
    check("race_state", 32'(db_estado), 32'h4);
    check("race_erro", 32'(erro), 32'd0);
    serve_chars(1);
    step();
    check("race_idle", 32'(db_estado), 32'h0);

    // Reset while waiting for the third character: no pronto, restart at 0.
    for (int i = 0; i < 3; i++) q_sel.push_back(i);
    mensurar = 1'b1; step(); mensurar = 1'b0;
    wait_for(W_MEDIR, "rst_wait_medir");
    step();
    pulse_medida();
    for (int i = 0; i < 3; i++) begin
      wait_for(W_TX, "rst_wait_tx");
      step();
      if (i < 2) pulse_envio();
    end
    check("rst_pre_state", 32'({db_estado, sel_char}), 32'({4'h5, 2'd2}));
    c_pr = n_pronto;
    #2 reset = 1'b0;
    #1;
    check("rst_async_outputs", 32'({zera, medir, transmitir, pronto, erro, sel_char, db_estado}), 32'd0);
    step(); step();
    reset = 1'b1;
    step(); step(); step();
    check("rst_no_pronto", 32'(n_pronto - c_pr), 32'd0);
    check("rst_idle", 32'(db_estado), 32'h0);
    check("rst_queue_drained", 32'(q_sel.size()), 32'd0);
    push_message();
    mensurar = 1'b1; step(); mensurar = 1'b0;
    run_message(2, 3);
    step();
    check("rst_restart_pronto", 32'(n_pronto - c_pr), 32'd1);

    // Held start: back-to-back messages, each opening with zera then medir.
    c_zera = n_zera;
    push_message();
    push_message();
    mensurar = 1'b1;
    step();
    check("held1_zera", 32'({zera, db_estado}), 32'({1'b1, 4'h1}));
    step();
    check("held1_medir", 32'(medir), 32'd1);
    run_message(1, 1);
    step();
    check("held_back_idle", 32'(db_estado), 32'h0);
    step();
    check("held2_zera", 32'({zera, db_estado}), 32'({1'b1, 4'h1}));
    step();
    check("held2_medir", 32'(medir), 32'd1);
    run_message(1, 1);
    mensurar = 1'b0;
    step(); step();
    check("held_end_idle", 32'(db_estado), 32'h0);
    check("held_zera_count", 32'(n_zera - c_zera), 32'd2);

    check("scoreboard_drained", 32'(q_sel.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
